// File: rtl/fifo_pop_stream_adapter.sv
// Read-side adapter: FIFO pop/1-cycle-latency read port -> valid/ready stream via a register skid buffer.
// Optional beat counter (beat_cnt port) is built when FIFO_STREAM_CNT_EN is defined.
module fifo_pop_stream_adapter #(
    parameter int WIDTH     = 16,
    parameter int BUF_DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           fifo_empty,
    output logic                           fifo_pop,
    input  logic                           fifo_valid,
    input  logic [WIDTH-1:0]               fifo_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy,
    output logic                           err_unexp
`ifdef FIFO_STREAM_CNT_EN
    ,
    output logic [15:0]                    beat_cnt
`endif
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(BUF_DEPTH);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             inflight_q;
    logic             err_q, err_d;
    logic [OCC_W:0]   pending;
    logic             capture;
    logic             deq;

    // Pops are budgeted against entries held plus the one read still in flight,
    // so a capture can never find the buffer full.
    assign pending  = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
    assign fifo_pop = !fifo_empty && !flush && (pending < DEPTH_EXT);

    assign capture   = fifo_valid && inflight_q && !flush;
    assign out_valid = (occ_q != '0);
    assign deq       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
    assign err_unexp = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q | (fifo_valid & ~inflight_q);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (capture) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (deq)     rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({capture, deq})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_pop;
            err_q      <= err_d;
        end
    end

    // Data storage needs no reset; contents are qualified by occ_q.
    always_ff @(posedge clk) begin
        if (capture) mem_q[wr_ptr_q] <= fifo_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(capture && !deq && occ_q == OCC_FULL))
                else $error("skid buffer overflow");
        end
    end

`ifdef FIFO_STREAM_CNT_EN
    logic [15:0] beat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   beat_q <= 16'd0;
        else if (deq) beat_q <= beat_q + 16'd1;
    end
    assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_fifo_pop_stream_adapter.sv
// Directed bench for fifo_pop_stream_adapter with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_pop_stream_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        fifo_valid;
    logic [15:0] fifo_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  occupancy;
    logic        err_unexp;
`ifdef FIFO_STREAM_CNT_EN
    logic [15:0] beat_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // FIFO model: push side written only by tasks, pop side only by the model process
    logic [15:0] mem [256];
    int          push_cnt = 0;
    int          pop_cnt  = 0;
    logic        mvalid;
    logic [15:0] mdata;
    logic        force_v = 1'b0;
    logic [15:0] exp_q [$];

    assign fifo_empty = (pop_cnt >= push_cnt);
    assign fifo_valid = mvalid | force_v;
    assign fifo_rdata = force_v ? 16'hDEAD : mdata;

    fifo_pop_stream_adapter #(.WIDTH(16), .BUF_DEPTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_valid (fifo_valid),
        .fifo_rdata (fifo_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .err_unexp  (err_unexp)
`ifdef FIFO_STREAM_CNT_EN
        ,
        .beat_cnt   (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mvalid <= 1'b0;
            mdata  <= 16'h0;
        end else begin
            mvalid <= fifo_pop;
            if (fifo_pop) begin
                mdata   <= mem[pop_cnt[7:0]];
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    task automatic push(input logic [15:0] d);
        mem[push_cnt[7:0]] = d;
        push_cnt = push_cnt + 1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        force_v = 1'b0;
        step(2);
        push_cnt = pop_cnt;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || err_unexp !== 1'b0 || fifo_pop !== 1'b0)
            $display("FAIL reset: out_valid=%b occ=%0d err=%b pop=%b, required 0/0/0/0",
                     out_valid, occupancy, err_unexp, fifo_pop);
        else n_pass++;
`ifdef FIFO_STREAM_CNT_EN
        n_checks++;
        if (beat_cnt !== 16'd0) $display("FAIL reset_beat_cnt: got %0d, required 0", beat_cnt);
        else n_pass++;
`endif
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic();
        int first_pop = -1;
        int first_v = -1;
        int last_v = -1;
        int beats = 0;
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            push(16'(i));
            exp_q.push_back(16'(i));
        end
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (fifo_pop && first_pop < 0) first_pop = c;
            if (out_valid && out_ready) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                beats++;
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL basic_data: extra beat %h", out_data);
                else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) $display("FAIL basic_data: got %h, required %h", out_data, e);
                    else n_pass++;
                end
            end
            step(1);
        end
        n_checks++;
        if (first_pop != 0 || first_v - first_pop != 2)
            $display("FAIL basic_latency: first_pop=%0d first_valid=%0d, required 0 and 2", first_pop, first_v);
        else n_pass++;
        n_checks++;
        if (beats != 8 || last_v - first_v != 7)
            $display("FAIL basic_back_to_back: beats=%0d span=%0d, required 8 and 7", beats, last_v - first_v);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        int beats = 0;
        int gaps = 0;
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            push(16'(i));
            exp_q.push_back(16'(i));
        end
        step(10);
        n_checks++;
        if (fifo_pop !== 1'b0 || occupancy !== 2'd3 || out_data !== 16'h0001)
            $display("FAIL bp_stall: pop=%b occ=%0d data=%h, required 0/3/0001", fifo_pop, occupancy, out_data);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            if (out_data !== 16'h0001 || out_valid !== 1'b1 || fifo_pop !== 1'b0) unstable++;
            step(1);
        end
        n_checks++;
        if (unstable != 0) $display("FAIL bp_hold: unstable cycles=%0d, required 0", unstable);
        else n_pass++;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 30 && beats < 8; c++) begin
            if (out_valid) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                beats++;
                n_checks++;
                if (out_data !== e) $display("FAIL bp_data: got %h, required %h", out_data, e);
                else n_pass++;
            end else gaps++;
            step(1);
        end
        n_checks++;
        if (beats != 8 || gaps != 0) $display("FAIL bp_no_gaps: beats=%0d gaps=%0d, required 8 and 0", beats, gaps);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_empty_boundary();
        int pops = 0;
        int beats = 0;
        int bad_pop = 0;
        logic [15:0] got = 16'h0;
        apply_reset();
        push(16'h0055);
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (fifo_pop) pops++;
            if (fifo_pop && fifo_empty) bad_pop++;
            if (out_valid) begin
                beats++;
                got = out_data;
            end
            step(1);
        end
        n_checks++;
        if (pops != 1 || beats != 1 || got !== 16'h0055 || bad_pop != 0)
            $display("FAIL empty_boundary: pops=%0d beats=%0d data=%h bad=%0d, required 1/1/0055/0",
                     pops, beats, got, bad_pop);
        else n_pass++;
    endtask

    task automatic test_flush();
        int beats = 0;
        logic [15:0] got = 16'h0;
        apply_reset();
        push(16'h0011);
        push(16'h0022);
        step(5);
        n_checks++;
        if (occupancy !== 2'd2) $display("FAIL flush_setup: occ=%0d, required 2", occupancy);
        else n_pass++;
        push(16'h0033);
        #1;
        n_checks++;
        if (fifo_pop !== 1'b1) $display("FAIL flush_pop_before: pop=%b, required 1", fifo_pop);
        else n_pass++;
        step(1);
        flush = 1'b1;
        #1;
        n_checks++;
        if (fifo_pop !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL flush_cycle: pop=%b out_valid=%b, required 0/1", fifo_pop, out_valid);
        else n_pass++;
        step(1);
        flush = 1'b0;
        #1;
        n_checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || err_unexp !== 1'b0)
            $display("FAIL flush_after: occ=%0d out_valid=%b err=%b, required 0/0/0", occupancy, out_valid, err_unexp);
        else n_pass++;
        push(16'h00AA);
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                beats++;
                got = out_data;
            end
            step(1);
        end
        n_checks++;
        if (beats != 1 || got !== 16'h00AA)
            $display("FAIL flush_refill: beats=%0d data=%h, required 1/00AA", beats, got);
        else n_pass++;
    endtask

    task automatic test_protocol_error();
        apply_reset();
        push(16'h0066);
        step(5);
        n_checks++;
        if (err_unexp !== 1'b0 || occupancy !== 2'd1)
            $display("FAIL perr_setup: err=%b occ=%0d, required 0/1", err_unexp, occupancy);
        else n_pass++;
        force_v = 1'b1;
        step(1);
        force_v = 1'b0;
        #1;
        n_checks++;
        if (err_unexp !== 1'b1 || occupancy !== 2'd1 || out_data !== 16'h0066)
            $display("FAIL perr_set: err=%b occ=%0d data=%h, required 1/1/0066", err_unexp, occupancy, out_data);
        else n_pass++;
        out_ready = 1'b1;
        step(4);
        n_checks++;
        if (err_unexp !== 1'b1 || occupancy !== 2'd0)
            $display("FAIL perr_sticky: err=%b occ=%0d, required 1/0", err_unexp, occupancy);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (err_unexp !== 1'b0) $display("FAIL perr_reset_clear: err=%b, required 0", err_unexp);
        else n_pass++;
    endtask

`ifdef FIFO_STREAM_CNT_EN
    task automatic test_beat_cnt();
        int delivered = 0;
        apply_reset();
        push_cnt = push_cnt + 70000;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 70100 && delivered < 70000; c++) begin
            if (out_valid) delivered++;
            step(1);
        end
        step(3);
        n_checks++;
        if (delivered != 70000 || beat_cnt !== 16'd4464)
            $display("FAIL beat_cnt: delivered=%0d beat_cnt=%0d, required 70000/4464", delivered, beat_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_boundary();
        test_flush();
        test_protocol_error();
`ifdef FIFO_STREAM_CNT_EN
        test_beat_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
